// File: rtl/processinho_pkg.sv
// Shared types and constants for the operand entry path.
// State encoding plus BCD digit limits.
package processinho_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        HOLD
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam int         DIGIT_W = 4;

endpackage

// File: rtl/bcd_mac_step.sv
// One decimal multiply-accumulate step: acc*10 + digit.
// The multiply uses shifts; the result is truncated to OUT_W.
module bcd_mac_step
    import processinho_pkg::*;
#(
    parameter int OUT_W = 10
) (
    input  logic [OUT_W-1:0]   acc,
    input  logic [DIGIT_W-1:0] digit,
    output logic [OUT_W-1:0]   acc_next
);

    // acc*10 = acc*8 + acc*2, then add the new digit
    always_comb begin
        acc_next = (acc << 3) + (acc << 1) + OUT_W'(digit);
    end

endmodule

// File: rtl/bcd_operand_entry.sv
// Collects BCD digits, converts them MSD-first to binary, and
// hands the operand out over valid/ready. Optional: OPERAND_ECHO_EN.
module bcd_operand_entry
    import processinho_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int OUT_W  = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DIGIT_W-1:0]    digit_in,
    input  logic                  digit_valid,
    input  logic                  clear,
    input  logic                  enter,
    output logic                  busy,
    output logic                  digit_err,
`ifdef OPERAND_ECHO_EN
    output logic [4*DIGITS-1:0]   echo_bcd,
`endif
    output logic [OUT_W-1:0]      bin_out,
    output logic                  bin_valid,
    input  logic                  bin_ready
);

    localparam int BUF_W  = DIGIT_W * DIGITS;
    localparam int CNT_W  = 3;
    localparam int STEP_W = 2;

    state_t              state_q, state_d;
    logic [BUF_W-1:0]    buffer_q, buffer_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [OUT_W-1:0]    acc_q, acc_d;
    logic [OUT_W-1:0]    bin_out_q, bin_out_d;
    logic                bin_valid_q, bin_valid_d;
    logic                err_q, err_d;

    logic [BUF_W-1:0]    shifted;
    logic [DIGIT_W-1:0]  nibble;
    logic [OUT_W-1:0]    mac_out;
    logic                last_step;
    logic                buf_full;
    int                  sel;

    bcd_mac_step #(
        .OUT_W (OUT_W)
    ) u_mac (
        .acc      (acc_q),
        .digit    (nibble),
        .acc_next (mac_out)
    );

    // Pick the nibble for this step, most significant first
    always_comb begin
        sel    = DIGITS - 1 - int'(step_q);
        nibble = buffer_q[sel*DIGIT_W +: DIGIT_W];
    end

    // Next-state logic: clear overrides everything, then per-state work
    always_comb begin
        state_d     = state_q;
        buffer_d    = buffer_q;
        count_d     = count_q;
        step_d      = step_q;
        acc_d       = acc_q;
        bin_out_d   = bin_out_q;
        bin_valid_d = bin_valid_q;
        err_d       = 1'b0;

        shifted              = buffer_q << DIGIT_W;
        shifted[DIGIT_W-1:0] = digit_in;
        last_step            = (step_q == STEP_W'(DIGITS - 1));
        buf_full             = (count_q == CNT_W'(DIGITS));

        if (clear) begin
            state_d     = IDLE;
            buffer_d    = '0;
            count_d     = '0;
            step_d      = '0;
            bin_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (enter) begin
                        state_d = CONVERT;
                        acc_d   = '0;
                        step_d  = '0;
                    end else if (digit_valid) begin
                        if (digit_in > BCD_MAX || buf_full) begin
                            err_d = 1'b1;
                        end else begin
                            buffer_d = shifted;
                            count_d  = count_q + CNT_W'(1);
                        end
                    end
                end
                CONVERT: begin
                    acc_d  = mac_out;
                    step_d = step_q + STEP_W'(1);
                    if (last_step) begin
                        state_d     = HOLD;
                        step_d      = '0;
                        bin_out_d   = mac_out;
                        bin_valid_d = 1'b1;
                    end
                end
                HOLD: begin
                    if (bin_valid_q && bin_ready) begin
                        state_d     = IDLE;
                        bin_valid_d = 1'b0;
                        buffer_d    = '0;
                        count_d     = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            buffer_q    <= '0;
            count_q     <= '0;
            step_q      <= '0;
            acc_q       <= '0;
            bin_out_q   <= '0;
            bin_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            buffer_q    <= buffer_d;
            count_q     <= count_d;
            step_q      <= step_d;
            acc_q       <= acc_d;
            bin_out_q   <= bin_out_d;
            bin_valid_q <= bin_valid_d;
            err_q       <= err_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign digit_err = err_q;
    assign bin_out   = bin_out_q;
    assign bin_valid = bin_valid_q;

`ifdef OPERAND_ECHO_EN
    assign echo_bcd = buffer_q;
`endif

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Directed testbench for bcd_operand_entry (DIGITS=3, OUT_W=10).
// Exercises echo_bcd when OPERAND_ECHO_EN is defined.
module tb_bcd_operand_entry;

    logic       clock;
    logic       reset;
    logic [3:0] digit_in;
    logic       digit_valid;
    logic       clear;
    logic       enter;
    logic       busy;
    logic       digit_err;
    logic [9:0] bin_out;
    logic       bin_valid;
    logic       bin_ready;
`ifdef OPERAND_ECHO_EN
    logic [11:0] echo_bcd;
`endif

    int vectors;
    int miscompares;

    bcd_operand_entry #(
        .DIGITS (3),
        .OUT_W  (10)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .clear       (clear),
        .enter       (enter),
        .busy        (busy),
        .digit_err   (digit_err),
`ifdef OPERAND_ECHO_EN
        .echo_bcd    (echo_bcd),
`endif
        .bin_out     (bin_out),
        .bin_valid   (bin_valid),
        .bin_ready   (bin_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [3:0] d);
        digit_in    = d;
        digit_valid = 1'b1;
        tick();
        digit_valid = 1'b0;
    endtask

    // Pulse enter, then wait (bounded) for bin_valid; lat = cycles after enter edge
    task automatic run_enter(output int lat);
        enter = 1'b1;
        tick();
        enter = 1'b0;
        lat = 0;
        while (!bin_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic handshake();
        bin_ready = 1'b1;
        tick();
        bin_ready = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if ({busy, bin_valid, digit_err, bin_out} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got busy=%b valid=%b err=%b out=%0d want all 0",
                     busy, bin_valid, digit_err, bin_out);
        end
    endtask

    task automatic test_basic();
        int lat;
        push(4'd1);
        push(4'd2);
        push(4'd3);
        bin_ready = 1'b1;
        run_enter(lat);
        vectors++;
        if (lat !== 3) begin
            miscompares++;
            $display("FAIL basic_latency got %0d want 3", lat);
        end
        vectors++;
        if (bin_out !== 10'd123 || bin_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_value got %0d/%b want 123/1", bin_out, bin_valid);
        end
        tick();
        bin_ready = 1'b0;
        vectors++;
        if (bin_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_release got valid=%b busy=%b want 0/0", bin_valid, busy);
        end
        run_enter(lat);
        vectors++;
        if (bin_out !== 10'd0 || bin_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_buffer_cleared got %0d/%b want 0/1", bin_out, bin_valid);
        end
        handshake();
    endtask

    task automatic test_full();
        int lat;
        push(4'd9);
        push(4'd9);
        push(4'd9);
        vectors++;
        if (digit_err !== 1'b0) begin
            miscompares++;
            $display("FAIL full_no_err got %b want 0", digit_err);
        end
        push(4'd7);
        vectors++;
        if (digit_err !== 1'b1) begin
            miscompares++;
            $display("FAIL full_err got %b want 1", digit_err);
        end
        tick();
        vectors++;
        if (digit_err !== 1'b0) begin
            miscompares++;
            $display("FAIL full_err_pulse got %b want 0", digit_err);
        end
        run_enter(lat);
        vectors++;
        if (bin_out !== 10'd999 || lat !== 3) begin
            miscompares++;
            $display("FAIL full_value got %0d lat %0d want 999 lat 3", bin_out, lat);
        end
        handshake();
    endtask

    task automatic test_bad_digit();
        int lat;
        push(4'hA);
        vectors++;
        if (digit_err !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_digit_err got %b want 1", digit_err);
        end
        push(4'd5);
        vectors++;
        if (digit_err !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_digit_next got %b want 0", digit_err);
        end
        run_enter(lat);
        vectors++;
        if (bin_out !== 10'd5 || bin_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_digit_value got %0d/%b want 5/1", bin_out, bin_valid);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        int lat;
        bit stable;
        push(4'd4);
        push(4'd2);
        run_enter(lat);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (bin_valid !== 1'b1 || bin_out !== 10'd42 || busy !== 1'b1) stable = 1'b0;
            tick();
        end
        vectors++;
        if (!stable || bin_out !== 10'd42) begin
            miscompares++;
            $display("FAIL hold_stable got %0d/%b want 42/1 for 10 cycles", bin_out, bin_valid);
        end
        handshake();
        vectors++;
        if (bin_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_release got %b want 0", bin_valid);
        end
    endtask

    task automatic test_clear_abort();
        int lat;
        bit quiet;
        push(4'd7);
        push(4'd8);
        enter = 1'b1;
        tick();
        enter = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        vectors++;
        if (busy !== 1'b0 || bin_valid !== 1'b0 || bin_out !== 10'd42) begin
            miscompares++;
            $display("FAIL clear_abort got busy=%b valid=%b out=%0d want 0/0/42",
                     busy, bin_valid, bin_out);
        end
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (bin_valid !== 1'b0) quiet = 1'b0;
            tick();
        end
        vectors++;
        if (!quiet) begin
            miscompares++;
            $display("FAIL clear_no_valid got valid after clear want 0");
        end
        push(4'd6);
        run_enter(lat);
        vectors++;
        if (bin_out !== 10'd6 || lat !== 3) begin
            miscompares++;
            $display("FAIL clear_reentry got %0d lat %0d want 6 lat 3", bin_out, lat);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        push(4'd7);
        push(4'd8);
        enter = 1'b1;
        tick();
        enter = 1'b0;
        reset = 1'b0;
        #1;
        vectors++;
        if ({busy, bin_valid, digit_err, bin_out} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_mid got busy=%b valid=%b out=%0d want 0/0/0",
                     busy, bin_valid, bin_out);
        end
        tick();
        reset = 1'b1;
        tick();
        tick();
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0 || bin_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_after got busy=%b valid=%b want 0/0", busy, bin_valid);
        end
    endtask

    task automatic test_edges();
        int lat;
        bit quiet;
        push(4'd5);
        run_enter(lat);
        handshake();
        run_enter(lat);
        vectors++;
        if (bin_out !== 10'd0 || bin_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL empty_enter got %0d/%b want 0/1", bin_out, bin_valid);
        end
        handshake();
        clear = 1'b1;
        enter = 1'b1;
        tick();
        clear = 1'b0;
        enter = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (busy !== 1'b0 || bin_valid !== 1'b0) quiet = 1'b0;
            tick();
        end
        vectors++;
        if (!quiet) begin
            miscompares++;
            $display("FAIL clear_beats_enter got busy=%b want IDLE", busy);
        end
        push(4'd2);
        digit_in    = 4'd7;
        digit_valid = 1'b1;
        enter       = 1'b1;
        tick();
        digit_valid = 1'b0;
        enter       = 1'b0;
        vectors++;
        if (digit_err !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL enter_digit_same got err=%b busy=%b want 0/1", digit_err, busy);
        end
        push(4'hF);
        vectors++;
        if (digit_err !== 1'b0) begin
            miscompares++;
            $display("FAIL convert_ignores_digit got err=%b want 0", digit_err);
        end
        lat = 0;
        while (!bin_valid && lat < 20) begin
            tick();
            lat++;
        end
        vectors++;
        if (bin_out !== 10'd2 || bin_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL enter_digit_value got %0d/%b want 2/1", bin_out, bin_valid);
        end
        handshake();
    endtask

`ifdef OPERAND_ECHO_EN
    task automatic test_echo();
        push(4'd3);
        push(4'd1);
        vectors++;
        if (echo_bcd !== 12'h031) begin
            miscompares++;
            $display("FAIL echo_value got %h want 031", echo_bcd);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        vectors++;
        if (echo_bcd !== 12'h000) begin
            miscompares++;
            $display("FAIL echo_clear got %h want 000", echo_bcd);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        digit_in    = 4'd0;
        digit_valid = 1'b0;
        clear       = 1'b0;
        enter       = 1'b0;
        bin_ready   = 1'b0;
        tick();
        tick();
        test_reset();
        reset = 1'b1;
        tick();
        test_basic();
        test_full();
        test_bad_digit();
        test_backpressure();
        test_clear_abort();
        test_reset_mid();
        test_edges();
`ifdef OPERAND_ECHO_EN
        test_echo();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
